// File: rtl/ahb5_fb_bridge.sv
// AHB5 subordinate to request/acknowledge peripheral bus bridge with an exclusive-access monitor.
// Optional ack timeout returning an AHB ERROR: define AHB_FB_BRIDGE_TIMEOUT_EN.
module ahb5_fb_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hsel,
  input  logic [ADDR_W-1:0]      haddr,
  input  logic                   hwrite,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hsize,
  input  logic                   hexcl,
  input  logic                   hready,
  input  logic [DATA_W-1:0]      hwdata,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic                   hexokay,
  output logic [DATA_W-1:0]      hrdata,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W/8-1:0]    bus_be,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_rdata,
  input  logic                   bus_err
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned LSB  = $clog2(BE_W);

  typedef enum logic [2:0] {StIdle, StReq, StErr1, StErr2, StXfail} state_e;

  state_e            state_q;
  logic              excl_q;
  logic              rsv_valid_q;
  logic [ADDR_W-1:0] rsv_addr_q;

  logic              accept;
  logic              size_err;
  logic              rsv_hit;
  logic [ADDR_W-1:0] addr_al;
  logic [7:0]        mask8;
  logic [BE_W-1:0]   be_mask;
  logic [BE_W-1:0]   be_acc;
  logic              unused_htrans0;

  assign accept         = hsel & hready & htrans[1];
  assign size_err       = 32'(hsize) > LSB;
  assign addr_al        = haddr & ~ADDR_W'(BE_W - 1);
  assign rsv_hit        = rsv_valid_q && (rsv_addr_q == addr_al);
  assign bus_wdata      = hwdata;
  assign unused_htrans0 = htrans[0];

  always_comb begin
    mask8 = 8'hFF;
    case (hsize)
      3'd0:    mask8 = 8'h01;
      3'd1:    mask8 = 8'h03;
      3'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
  end

  assign be_mask = mask8[BE_W-1:0];
  // Lanes shifted past the top of the bus are dropped rather than flagged.
  assign be_acc  = be_mask << haddr[LSB-1:0];

`ifdef AHB_FB_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hreadyout   <= 1'b1;
      hresp       <= 1'b0;
      hexokay     <= 1'b0;
      hrdata      <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      excl_q      <= 1'b0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
`ifdef AHB_FB_BRIDGE_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      hexokay <= 1'b0;
      unique case (state_q)
        StIdle, StErr2: begin
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          if (accept) begin
            bus_addr  <= addr_al;
            bus_be    <= be_acc;
            bus_we    <= hwrite;
            excl_q    <= hexcl;
            hreadyout <= 1'b0;
            if (size_err) begin
              state_q     <= StErr1;
              hresp       <= 1'b1;
              rsv_valid_q <= 1'b0;
            end else if (hexcl && hwrite && !rsv_hit) begin
              // Failed store-exclusive: never reaches the downstream bus.
              state_q     <= StXfail;
              rsv_valid_q <= 1'b0;
            end else begin
              state_q <= StReq;
              bus_req <= 1'b1;
              if (hexcl && hwrite) rsv_valid_q <= 1'b0;
`ifdef AHB_FB_BRIDGE_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        StReq: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_err) begin
              state_q     <= StErr1;
              hresp       <= 1'b1;
              rsv_valid_q <= 1'b0;
            end else begin
              state_q   <= StIdle;
              hreadyout <= 1'b1;
              hexokay   <= excl_q;
              if (!bus_we) hrdata <= bus_rdata;
              if (excl_q && !bus_we) begin
                rsv_valid_q <= 1'b1;
                rsv_addr_q  <= bus_addr;
              end
              if (!excl_q && bus_we && (rsv_addr_q == bus_addr)) rsv_valid_q <= 1'b0;
            end
          end
`ifdef AHB_FB_BRIDGE_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_req     <= 1'b0;
            state_q     <= StErr1;
            hresp       <= 1'b1;
            rsv_valid_q <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end
        StErr1: begin
          state_q   <= StErr2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        StXfail: begin
          state_q   <= StIdle;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb5_fb_bridge.sv
// Scoreboard bench for ahb5_fb_bridge: AHB completions and downstream requests checked against
// hand-computed expectations queued by the stimulus.
module tb_ahb5_fb_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel, hwrite, hexcl;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready;
  logic        hreadyout, hresp, hexokay;
  logic [31:0] hrdata;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        resp;
    logic        exok;
    logic [31:0] rdata;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    logic        err;
    logic        noack;
    logic [31:0] rdata;
  } bus_exp_t;

  ahb_exp_t ahb_q[$];
  bus_exp_t bus_q[$];

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb5_fb_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hexcl(hexcl), .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
    .hresp(hresp), .hexokay(hexokay), .hrdata(hrdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic [31:0] wdata, input int delay, input logic err,
                          input logic noack, input logic [31:0] rdata);
    bus_exp_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    b.delay = delay; b.err = err; b.noack = noack; b.rdata = rdata;
    bus_q.push_back(b);
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic excl, input logic [31:0] wdata);
    logic ok;
    hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size; hexcl = excl; htrans = 2'd2;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = hready;
      @(posedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_wait actual=hready_low required=hready_high addr=%0h", addr);
    end
    #1;
    hsel = 1'b0; htrans = 2'd0; hexcl = 1'b0; hwdata = wdata;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic excl, input logic [31:0] wdata, input logic resp,
                      input logic exok, input logic [31:0] rdata, input int waits);
    ahb_exp_t e;
    e.resp = resp; e.exok = exok; e.rdata = rdata; e.waits = waits;
    ahb_q.push_back(e);
    addr_phase(addr, wr, size, excl, wdata);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && ahb_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // AHB completion monitor
  initial begin
    logic     pend = 1'b0;
    int       waits = 0;
    logic     lwh = 1'b0;
    ahb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        waits = 0;
      end else begin
        if (pend) begin
          if (!hreadyout) begin
            waits++;
            lwh = hresp;
          end else begin
            if (ahb_q.size() == 0) begin
              errors++;
              $display("FAIL ahb_unexpected_completion actual=1 required=0");
            end else begin
              e = ahb_q.pop_front();
              chk("hresp", hresp, e.resp);
              chk("hexokay", hexokay, e.exok);
              chk("hrdata", hrdata, e.rdata);
              chk("wait_cycles", waits, e.waits);
              if (e.waits > 0) chk("first_phase_hresp", lwh, e.resp);
            end
            pend = 1'b0;
            waits = 0;
          end
        end
        if (hsel && hready && htrans[1]) pend = 1'b1;
      end
    end
  end

  // Downstream responder and request checker
  initial begin
    logic     in_req = 1'b0;
    int       age = 0;
    bus_exp_t cur;
    cur.noack = 1'b1; cur.delay = -1; cur.we = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (rst_n && bus_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          age = 0;
          if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected_req actual=1 required=0 addr=%0h", bus_addr);
            cur.noack = 1'b0; cur.delay = 0; cur.err = 1'b0; cur.rdata = '0; cur.we = 1'b0;
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_be", bus_be, cur.be);
            chk("bus_we", bus_we, cur.we);
            if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
          end
        end
        if (!cur.noack && age == cur.delay) begin
          bus_ack = 1'b1;
          bus_err = cur.err;
          bus_rdata = cur.rdata;
          in_req = 1'b0;
        end
        age++;
      end else begin
        if (in_req && cur.noack && cur.delay >= 0) chk("bus_req_cycles", age, cur.delay);
        in_req = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'd0; hsize = 3'd0; hexcl = 1'b0;
    hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hexokay", hexokay, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic reads/writes, lane truncation, errors; issued back-to-back
    push_bus(32'h100, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
    xfer(32'h100, 1'b0, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1);
    push_bus(32'h200, 4'h8, 1'b1, 32'hAA000000, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h203, 1'b1, 3'd0, 1'b0, 32'hAA000000, 1'b0, 1'b0, 32'hDEADBEEF, 1);
    push_bus(32'h104, 4'hF, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h12345678);
    xfer(32'h104, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 2);
    push_bus(32'h300, 4'hC, 1'b0, 32'h0, 2, 1'b0, 1'b0, 32'hCAFE0000);
    xfer(32'h302, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hCAFE0000, 3);
    xfer(32'h308, 1'b0, 3'd3, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE0000, 1);
    push_bus(32'h200, 4'h8, 1'b1, 32'h5A5A5A5A, 1, 1'b0, 1'b0, 32'h0);
    xfer(32'h203, 1'b1, 3'd1, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hCAFE0000, 2);
    drain();

    // Exclusive pair succeeds, repeat fails
    push_bus(32'h40, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h11112222);
    xfer(32'h40, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h11112222, 1);
    push_bus(32'h40, 4'hF, 1'b1, 32'h33, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h40, 1'b1, 3'd2, 1'b1, 32'h33, 1'b0, 1'b1, 32'h11112222, 1);
    xfer(32'h40, 1'b1, 3'd2, 1'b1, 32'h44, 1'b0, 1'b0, 32'h11112222, 1);
    // Plain write to the reserved word kills the reservation
    push_bus(32'h40, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h5);
    xfer(32'h40, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h5, 1);
    push_bus(32'h40, 4'hF, 1'b1, 32'h66, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h40, 1'b1, 3'd2, 1'b0, 32'h66, 1'b0, 1'b0, 32'h5, 1);
    xfer(32'h40, 1'b1, 3'd2, 1'b1, 32'h77, 1'b0, 1'b0, 32'h5, 1);
    // Plain write elsewhere leaves it intact
    push_bus(32'h80, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h6);
    xfer(32'h80, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h6, 1);
    push_bus(32'h84, 4'hF, 1'b1, 32'h88, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h84, 1'b1, 3'd2, 1'b0, 32'h88, 1'b0, 1'b0, 32'h6, 1);
    push_bus(32'h80, 4'hF, 1'b1, 32'h99, 0, 1'b0, 1'b0, 32'h0);
    xfer(32'h80, 1'b1, 3'd2, 1'b1, 32'h99, 1'b0, 1'b1, 32'h6, 1);
    // An ERROR response clears it
    push_bus(32'h80, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h7);
    xfer(32'h80, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h7, 1);
    push_bus(32'h90, 4'hF, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'hBAD);
    xfer(32'h90, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h7, 2);
    xfer(32'h80, 1'b1, 3'd2, 1'b1, 32'hAB, 1'b0, 1'b0, 32'h7, 1);
    // Address mismatch fails
    push_bus(32'h40, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h8);
    xfer(32'h40, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h8, 1);
    xfer(32'h44, 1'b1, 3'd2, 1'b1, 32'hCD, 1'b0, 1'b0, 32'h8, 1);
    drain();

`ifdef AHB_FB_BRIDGE_TIMEOUT_EN
    push_bus(32'h600, 4'hF, 1'b0, 32'h0, 4, 1'b0, 1'b1, 32'h0);
    xfer(32'h600, 1'b0, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 5);
    drain();
`endif

    // Reset mid-REQ abandons the request and the reservation
    push_bus(32'h40, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h9);
    xfer(32'h40, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, 1'b1, 32'h9, 1);
    drain();
    push_bus(32'h500, 4'hF, 1'b0, 32'h0, -1, 1'b0, 1'b1, 32'h0);
    addr_phase(32'h500, 1'b0, 3'd2, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_req_bus_req", bus_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", bus_req, 1'b0);
    chk("rst_mid_hreadyout", hreadyout, 1'b1);
    chk("rst_mid_hrdata", hrdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xfer(32'h40, 1'b1, 3'd2, 1'b1, 32'hEF, 1'b0, 1'b0, 32'h0, 1);
    push_bus(32'h100, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
    xfer(32'h100, 1'b0, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1);
    drain();

    chk("ahb_queue_empty", ahb_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
